// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shift/rotate in both directions,
// single-step or counted bursts with busy/done status.
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] R,
  input  logic             L,
  input  logic             E,
  input  logic [1:0]       mode,
  input  logic             W,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_bmode;

  logic [1:0]       w_mode;
  logic [WIDTH-1:0] w_shift;
  logic             w_last;

  // A running burst uses the mode latched at start; otherwise live mode.
  assign w_mode = (r_state == S_RUN) ? r_bmode : mode;
  assign w_last = (r_cnt == CNT_W'(1));

  // Next register value for one shift/rotate step in the effective mode.
  always_comb begin
    w_shift = r_q;
    case (w_mode)
      2'b00:   w_shift = {W, r_q[WIDTH-1:1]};
      2'b01:   w_shift = {r_q[WIDTH-2:0], W};
      2'b10:   w_shift = {r_q[0], r_q[WIDTH-1:1]};
      default: w_shift = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    endcase
  end

  // Register, burst counter and control state; load overrides everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bmode <= 2'b00;
    end else if (L) begin
      r_q     <= R;
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_RUN: begin
          r_q   <= w_shift;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (start) begin
            r_cnt   <= n;
            r_bmode <= mode;
            r_state <= (n != '0) ? S_RUN : S_DONE;
          end else if (E) begin
            r_q <= w_shift;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q    = r_q;
  // Right-moving modes drop bit 0, left-moving modes drop the MSB.
  assign so   = w_mode[0] ? r_q[WIDTH-1] : r_q[0];
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed cases
// plus randomized traffic against a behavioural model.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] R;
  logic             L, E, W, start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] q;
  logic             so, busy, done;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .R(R), .L(L), .E(E),
    .mode(mode), .W(W), .start(start), .n(n),
    .q(q), .so(so), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  // Behavioural model: register value as an integer, a count of
  // shifts still owed by the current burst, and a pending done flag.
  int unsigned m_q;
  int          m_left;
  bit          m_done;
  int unsigned m_bmode;

  function automatic int unsigned step(int unsigned v, int unsigned md,
                                       int unsigned win);
    int unsigned mask = (1 << WIDTH) - 1;
    case (md)
      0: return (v >> 1) | (win << (WIDTH - 1));
      1: return ((v << 1) & mask) | win;
      2: return (v >> 1) | ((v & 1) << (WIDTH - 1));
      default: return ((v << 1) & mask) | (v >> (WIDTH - 1));
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q = 0; m_left = 0; m_done = 0; m_bmode = 0;
    end else if (L) begin
      m_q = R; m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_q = step(m_q, m_bmode, W);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_bmode = mode;
      if (n == 0) m_done = 1;
      else m_left = n;
    end else if (E) begin
      m_q = step(m_q, mode, W);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      int unsigned em;
      em = (m_left > 0) ? m_bmode : mode;
      chk("q", q, m_q);
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("so", so, (em & 1) ? (m_q >> (WIDTH - 1)) & 1 : m_q & 1);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    L = 1'b1; R = v;
    tick();
    L = 1'b0;
  endtask

  initial begin
    reset = 1'b1; R = '0; L = 0; E = 0; W = 0; start = 0;
    mode = 2'b00; n = '0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_so", so, 0);
    tick(); tick();
    reset = 1'b0;
    cmp_en = 1'b1;

    // Load wins over E and start
    L = 1; R = 8'hA5; E = 1; start = 1;
    tick();
    chk("load_q", q, 8'hA5);
    chk("load_busy", busy, 0);
    chk("load_done", done, 0);
    L = 0; E = 0; start = 0;

    // Shift right with W=1
    load(8'h00);
    mode = 2'b00; W = 1; E = 1;
    tick(); chk("sr1", q, 8'h80);
    tick(); chk("sr2", q, 8'hC0);
    tick(); chk("sr3", q, 8'hE0);
    E = 0; W = 0;

    // Rotate left
    load(8'h81);
    mode = 2'b11; E = 1;
    tick(); E = 0;
    chk("rl_q", q, 8'h03);
    chk("rl_so", so, 0);

    // Burst rotate right by 3
    load(8'h01);
    mode = 2'b10; n = 3; start = 1;
    tick(); start = 0; mode = 2'b01; E = 1;
    chk("b_st_q", q, 8'h01); chk("b_st_busy", busy, 1);
    tick(); chk("b1_q", q, 8'h80); chk("b1_busy", busy, 1);
    tick(); chk("b2_q", q, 8'h40); chk("b2_busy", busy, 1);
    tick(); chk("b3_q", q, 8'h20); chk("b3_busy", busy, 0);
    chk("b3_done", done, 1);
    E = 0;
    tick(); chk("b_idle_done", done, 0); chk("b_idle_q", q, 8'h20);

    // Zero-length burst
    n = 0; start = 1;
    tick(); start = 0;
    chk("z_done", done, 1); chk("z_busy", busy, 0); chk("z_q", q, 8'h20);
    tick(); chk("z_done2", done, 0); chk("z_busy2", busy, 0);

    // Abort a burst with a load on the 2nd RUN edge
    load(8'h00);
    mode = 2'b01; n = 5; W = 1; start = 1;
    tick(); start = 0;
    tick(); chk("ab1_q", q, 8'h01);
    L = 1; R = 8'h3C;
    tick(); L = 0;
    chk("ab_q", q, 8'h3C); chk("ab_busy", busy, 0); chk("ab_done", done, 0);
    tick(); chk("ab_done2", done, 0); chk("ab_q2", q, 8'h3C);
    W = 0;

    // Asynchronous reset mid-burst
    n = 4; mode = 2'b00; start = 1;
    tick(); start = 0;
    tick();
    #1 reset = 1;
    #1;
    chk("ra_q", q, 0); chk("ra_busy", busy, 0); chk("ra_done", done, 0);
    #2 reset = 0;
    tick(); chk("ra_done2", done, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      L     = ($urandom_range(15) == 0);
      R     = WIDTH'($urandom);
      E     = $urandom_range(1);
      W     = $urandom_range(1);
      start = ($urandom_range(3) == 0);
      mode  = 2'($urandom);
      n     = CNT_W'($urandom);
      if ($urandom_range(199) == 0) begin
        #1 reset = 1;
        #1;
        chk("rnd_rst_q", q, 0);
        chk("rnd_rst_busy", busy, 0);
        #1 reset = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
